// File: rtl/onewire_byte_seq_if.sv
// Command, response and Avalon MM master signals of the 1-Wire byte sequencer.
// The master modport is the sequencer's view; slave is the command source plus 1-Wire master.
interface onewire_byte_seq_if #(
  parameter int ADW = 32
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [7:0]     cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_data;
  logic           avalon_read;
  logic           avalon_write;
  logic [ADW-1:0] avalon_writedata;
  logic [ADW-1:0] avalon_readdata;
  logic           avalon_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, avalon_readdata, avalon_waitrequest,
    output cmd_ready, rsp_valid, rsp_data, avalon_read, avalon_write, avalon_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, avalon_readdata, avalon_waitrequest,
    input  cmd_ready, rsp_valid, rsp_data, avalon_read, avalon_write, avalon_writedata
  );
endinterface

// File: rtl/onewire_byte_seq.sv
// Byte-level command sequencer: expands reset/write/read byte commands into 1-Wire
// bit cycles on the onewire master's Avalon port and polls each bit for completion.
module onewire_byte_seq #(
  parameter int PD  = 8,
  parameter int ADW = 32
) (
  input logic                clk,
  input logic                rst,
  onewire_byte_seq_if.master bus
);

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam int GW = (PD > 1) ? $clog2(PD) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(PD - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_GAP  = 3'd2,
    S_RD   = 3'd3,
    S_EVAL = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [1:0]     op_r, op_nxt_s;
  logic [7:0]     shift_r, shift_nxt_s;
  logic [3:0]     bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]     result_r, result_nxt_s;
  logic [GW-1:0]  gap_cnt_r, gap_cnt_nxt_s;
  logic           rd_bit_r, rd_bit_nxt_s;
  logic           rd_done_r, rd_done_nxt_s;

  logic           cmd_ready_r, cmd_ready_nxt_s;
  logic           rsp_valid_r, rsp_valid_nxt_s;
  logic [7:0]     rsp_data_r, rsp_data_nxt_s;
  logic           av_read_r, av_read_nxt_s;
  logic           av_write_r, av_write_nxt_s;
  logic [ADW-1:0] av_wdata_r, av_wdata_nxt_s;

  // Only the sampled-line and cycle-complete bits of readdata carry meaning.
  logic unused_rd_s;
  assign unused_rd_s = ^{bus.avalon_readdata[ADW-1:5], bus.avalon_readdata[3:1]};

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      op_r        <= 2'b00;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 4'd0;
      result_r    <= 8'h00;
      gap_cnt_r   <= '0;
      rd_bit_r    <= 1'b0;
      rd_done_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      av_read_r   <= 1'b0;
      av_write_r  <= 1'b0;
      av_wdata_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      op_r        <= op_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      result_r    <= result_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
      rd_bit_r    <= rd_bit_nxt_s;
      rd_done_r   <= rd_done_nxt_s;
      cmd_ready_r <= cmd_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      av_read_r   <= av_read_nxt_s;
      av_write_r  <= av_write_nxt_s;
      av_wdata_r  <= av_wdata_nxt_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt_s   = state_r;
    op_nxt_s      = op_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    result_nxt_s  = result_r;
    gap_cnt_nxt_s = gap_cnt_r;
    rd_bit_nxt_s  = rd_bit_r;
    rd_done_nxt_s = rd_done_r;
    case (state_r)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt_s   = S_WR;
          op_nxt_s      = (bus.cmd_op == OP_RST) ? OP_RST :
                          (bus.cmd_op == OP_WR)  ? OP_WR : OP_RD;
          shift_nxt_s   = bus.cmd_data;
          bit_cnt_nxt_s = 4'd0;
          result_nxt_s  = 8'h00;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR: begin
        if (!bus.avalon_waitrequest) begin
          state_nxt_s   = S_GAP;
          gap_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = S_WR;
        end
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = S_RD;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
        end
      end
      S_RD: begin
        if (!bus.avalon_waitrequest) begin
          state_nxt_s   = S_EVAL;
          rd_bit_nxt_s  = bus.avalon_readdata[0];
          rd_done_nxt_s = bus.avalon_readdata[4];
        end else begin
          state_nxt_s = S_RD;
        end
      end
      S_EVAL: begin
        // Completion flag still clear: the bit cycle is running, poll again after a gap.
        if (!rd_done_r) begin
          state_nxt_s   = S_GAP;
          gap_cnt_nxt_s = '0;
        end else if (op_r == OP_RST) begin
          result_nxt_s = {7'b0000000, ~rd_bit_r};
          state_nxt_s  = S_RSP;
        end else begin
          result_nxt_s  = {rd_bit_r, result_r[7:1]};
          shift_nxt_s   = {1'b0, shift_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          state_nxt_s   = (bit_cnt_r == 4'd7) ? S_RSP : S_WR;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RSP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a register.
  always_comb begin
    cmd_ready_nxt_s = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    av_read_nxt_s   = 1'b0;
    av_write_nxt_s  = 1'b0;
    av_wdata_nxt_s  = '0;
    rsp_data_nxt_s  = rsp_data_r;
    case (state_nxt_s)
      S_IDLE: cmd_ready_nxt_s = 1'b1;
      S_WR: begin
        av_write_nxt_s = 1'b1;
        if (op_nxt_s == OP_RST) begin
          av_wdata_nxt_s[1] = 1'b1;
        end else if (op_nxt_s == OP_RD) begin
          av_wdata_nxt_s[2] = 1'b1;
        end else begin
          av_wdata_nxt_s[2] = shift_nxt_s[0];
        end
      end
      S_RD:  av_read_nxt_s = 1'b1;
      S_RSP: begin
        rsp_valid_nxt_s = 1'b1;
        rsp_data_nxt_s  = result_nxt_s;
      end
      default: begin
        cmd_ready_nxt_s = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready        = cmd_ready_r;
  assign bus.rsp_valid        = rsp_valid_r;
  assign bus.rsp_data         = rsp_data_r;
  assign bus.avalon_read      = av_read_r;
  assign bus.avalon_write     = av_write_r;
  assign bus.avalon_writedata = av_wdata_r;

endmodule

// File: doc/onewire_byte_seq.md
# onewire_byte_seq

Byte-level command sequencer that sits directly upstream of the `onewire` master and drives its Avalon MM slave port. It accepts reset/write-byte/read-byte commands on a valid/ready interface, expands each command into 1-Wire bit cycles, polls the master's completion flag, and returns the presence bit or the assembled byte on a response handshake.

## Interface
- `PD`, 8: idle clock cycles between the end of one Avalon transfer and the next poll read (≥1).
- `ADW`, 32: Avalon data width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer accepts command (high only in IDLE).
- `cmd_op`  in  2  00 reset pulse, 01 write byte, 10 read byte, 11 treated as 10.
- `cmd_data`  in  8  byte to write (ignored for 00/10/11).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_data`  out  8  read byte; for reset, bit0 = presence (1 = slave present), bits 7:1 = 0; for write, last sampled byte.
- `avalon_read`  out  1  Avalon read strobe.
- `avalon_write`  out  1  Avalon write strobe.
- `avalon_writedata`  out  ADW  bit1 = reset pulse, bit2 = bit value to transmit, others 0.
- `avalon_readdata`  in  ADW  bit0 = sampled line, bit4 = cycle complete.
- `avalon_waitrequest`  in  1  slave stall.

## Operation
- States: IDLE, WR, GAP, RD, EVAL, RSP.
- IDLE: `cmd_ready`=1; on `cmd_valid`: latch op, data into shift register, clear bit counter and result, go WR.
- WR: assert `avalon_write`; writedata = 0x2 for reset, else {bit2 = shift[0]} i.e. 0x4 for '1', 0x0 for '0'. Read-byte transmits '1' every bit (0x4). Hold until `~avalon_waitrequest`, then GAP.
- GAP: count PD cycles, then RD.
- RD: assert `avalon_read`; hold until `~avalon_waitrequest`; capture readdata on that edge; go EVAL.
- EVAL (one cycle): if captured bit4 = 0 → GAP (poll again). If 1: reset op → result[0] = ~bit0, go RSP. Byte op → result = {bit0, result[7:1]} (LSB first), shift register >> 1, counter +1; counter reached 8 → RSP, else WR.
- RSP: `rsp_valid`=1, `rsp_data`=result; on `rsp_ready` → IDLE.
- Only one of `avalon_read`/`avalon_write` asserted at any time; both low outside WR/RD.
- Strobes, address-free writedata and commands are stable while waitrequest is high.
- No timeout: polling continues until bit4 is seen.

## Timing
- Reset values: `cmd_ready`=1 (IDLE), `rsp_valid`=0, `rsp_data`=0, `avalon_read`=0, `avalon_write`=0, `avalon_writedata`=0; counters 0.
- Reset mid-operation aborts immediately; strobes drop asynchronously; no partial response emitted.
- Command accept edge → `avalon_write` high next cycle.
- Transfer edge (strobe & ~waitrequest) → strobe low next cycle.
- Write transfer to first read strobe: PD+1 cycles; each failed poll adds EVAL + PD + read duration.
- Zero-wait slave, completion on first poll: per bit 1 (WR) + PD (GAP) + 1 (RD) + 1 (EVAL) = PD+3 cycles.
- Final EVAL → `rsp_valid` next cycle; `rsp_valid` held until accepted; accept edge → `cmd_ready` next cycle.
- Bit counter 4 bits, terminal value 8; no wrap.

## Test plan
- Reset cmd, slave model returns bit4=1/bit0=0 on first poll → one write of 0x00000002, one read, `rsp_data`=0x01; with bit0=1 → `rsp_data`=0x00.
- Write byte 0xA5, zero-wait slave → 8 writes with data sequence 0x4,0x0,0x4,0x0,0x0,0x4,0x0,0x4; `rsp_valid` after 8×(PD+3)+1 cycles.
- Read byte, slave returns bit0 pattern 1,0,1,1,0,0,1,0 → all writes 0x4, `rsp_data`=0x4D.
- Slave holds waitrequest 3 cycles and returns bit4=0 on two polls → strobes held stable, 3 reads per bit, correct final byte.
- `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, new `cmd_valid` ignored until accept.
- Assert `rst` during bit 3 of a write → all outputs at reset values same cycle; next command runs cleanly from bit 0.
